cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/rv32i_types.sv | 23 ++
 rtl/cache_arbiter.sv | 133 +++++++++++++
 tb/tb_cache_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types for the cache-to-memory arbiter: FSM states, grant id, cacheline default.
// Also holds the saturating counter helper used by the arbiter.
package rv32i_types;

    localparam int LINE_W_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates icache/dcache line fills and dcache writebacks onto one burst memory port.
// Request reaches memory one cycle after grant; requesters wait for their resp, and ties alternate.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_W = LINE_W_DEFAULT,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_resp,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic [31:0]       i_grant_cnt,
    output logic [31:0]       d_grant_cnt
);

    arb_state_t        state;
    arb_state_t        next_state;
    grant_t            last_grant;
    logic [ADDR_W-1:0] lat_addr;
    logic [LINE_W-1:0] lat_wdata;
    logic              lat_write;
    logic              i_req;
    logic              d_req;

    assign i_req = i_mem_read;
    assign d_req = d_mem_read | d_mem_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                // On a tie, serve whoever did not get the previous grant
                if (i_req && d_req) begin
                    next_state = (last_grant == GRANT_I) ? SERVE_D : SERVE_I;
                end else if (i_req) begin
                    next_state = SERVE_I;
                end else if (d_req) begin
                    next_state = SERVE_D;
                end
            end
            SERVE_I: if (mem_resp) next_state = DONE;
            SERVE_D: if (mem_resp) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Transaction is captured at grant so requesters may change their inputs mid-burst
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_write  <= 1'b0;
            last_grant <= GRANT_I;
        end else if (state == IDLE) begin
            if (next_state == SERVE_I) begin
                lat_addr   <= i_mem_addr;
                lat_wdata  <= '0;
                lat_write  <= 1'b0;
                last_grant <= GRANT_I;
            end else if (next_state == SERVE_D) begin
                lat_addr   <= d_mem_addr;
                lat_wdata  <= d_mem_wdata;
                lat_write  <= d_mem_write;
                last_grant <= GRANT_D;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
        end else if (mem_resp) begin
            if (state == SERVE_I) i_grant_cnt <= sat_inc(i_grant_cnt);
            if (state == SERVE_D) d_grant_cnt <= sat_inc(d_grant_cnt);
        end
    end

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        i_mem_resp  = 1'b0;
        d_mem_resp  = 1'b0;
        i_mem_rdata = '0;
        d_mem_rdata = '0;
        unique case (state)
            SERVE_I: begin
                mem_read   = ~lat_write;
                mem_write  = lat_write;
                i_mem_resp = mem_resp;
                if (mem_resp) i_mem_rdata = mem_rdata;
            end
            SERVE_D: begin
                mem_read   = ~lat_write;
                mem_write  = lat_write;
                d_mem_resp = mem_resp;
                if (mem_resp) d_mem_rdata = mem_rdata;
            end
            default: begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        endcase
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single fill, ties, writeback, spurious resp, mid-burst reset.
module tb_cache_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_mem_read;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [LINE_W-1:0] i_mem_rdata;
    logic              i_mem_resp;
    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [LINE_W-1:0] d_mem_wdata;
    logic [LINE_W-1:0] d_mem_rdata;
    logic              d_mem_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;
    logic [31:0]       i_grant_cnt;
    logic [31:0]       d_grant_cnt;

    int checks = 0;
    int errors = 0;

    logic [LINE_W-1:0] pat_a5;
    logic [LINE_W-1:0] pat_1234;
    logic [LINE_W-1:0] pat_d;
    logic [LINE_W-1:0] pat_i;

    cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
        .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
        .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pat_a5   = {32{8'hA5}};
        pat_1234 = {32{8'h12, 8'h34}} >> 0;
        pat_d    = {64{4'hD}};
        pat_i    = {64{4'h3}};
        reset = 1'b1;
        i_mem_read = 1'b0; i_mem_addr = '0;
        d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_addr = '0; d_mem_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_i_cnt", i_grant_cnt, 0);
        chk("rst_d_cnt", d_grant_cnt, 0);
        cyc();
        reset = 1'b0;

        // Single icache fill, address change mid-burst, resp after 4 cycles
        i_mem_read = 1'b1; i_mem_addr = 32'h0000_0060;
        #1 chk("t0_mem_read_low", mem_read, 0);
        cyc();
        chk("t1_mem_read", mem_read, 1);
        chk("t1_mem_addr", mem_addr, 32'h0000_0060);
        chk("t1_mem_write", mem_write, 0);
        i_mem_addr = 32'hDEAD_BEE0;
        cyc();
        chk("t2_addr_held", mem_addr, 32'h0000_0060);
        cyc();
        cyc();
        chk("t4_mem_read", mem_read, 1);
        cyc();
        mem_resp = 1'b1; mem_rdata = pat_a5;
        #1;
        chk("t5_mem_read", mem_read, 1);
        chk("t5_i_resp", i_mem_resp, 1);
        chk("t5_i_rdata", i_mem_rdata, pat_a5);
        chk("t5_d_resp", d_mem_resp, 0);
        chk("t5_d_rdata", d_mem_rdata, 0);
        chk("t5_i_cnt_pre", i_grant_cnt, 0);
        cyc();
        mem_resp = 1'b0; i_mem_read = 1'b0;
        #1;
        chk("done_mem_read", mem_read, 0);
        chk("done_i_resp", i_mem_resp, 0);
        chk("done_i_rdata", i_mem_rdata, 0);
        chk("done_i_cnt", i_grant_cnt, 1);
        cyc();

        // Spurious resp while idle
        mem_resp = 1'b1;
        #1;
        chk("spur_i_resp", i_mem_resp, 0);
        chk("spur_d_resp", d_mem_resp, 0);
        chk("spur_i_rdata", i_mem_rdata, 0);
        cyc();
        mem_resp = 1'b0;
        chk("spur_i_cnt", i_grant_cnt, 1);
        chk("spur_d_cnt", d_grant_cnt, 0);

        // Tie right after reset: D first, then I
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("tie_rst_i_cnt", i_grant_cnt, 0);
        i_mem_read = 1'b1; i_mem_addr = 32'h0000_0100;
        d_mem_read = 1'b1; d_mem_addr = 32'h0000_0200;
        cyc();
        chk("tie1_addr_d", mem_addr, 32'h0000_0200);
        chk("tie1_mem_read", mem_read, 1);
        mem_resp = 1'b1; mem_rdata = pat_d;
        #1;
        chk("tie1_d_resp", d_mem_resp, 1);
        chk("tie1_d_rdata", d_mem_rdata, pat_d);
        chk("tie1_i_resp", i_mem_resp, 0);
        cyc();
        // resp held high through DONE must be ignored
        chk("done_resp_ign_d", d_mem_resp, 0);
        chk("done_resp_ign_i", i_mem_resp, 0);
        chk("tie1_d_cnt", d_grant_cnt, 1);
        cyc();
        mem_resp = 1'b0;
        chk("tie_idle_d_cnt", d_grant_cnt, 1);
        chk("tie_idle_mem_read", mem_read, 0);
        cyc();
        chk("tie2_addr_i", mem_addr, 32'h0000_0100);
        chk("tie2_mem_read", mem_read, 1);
        mem_resp = 1'b1; mem_rdata = pat_i;
        #1;
        chk("tie2_i_resp", i_mem_resp, 1);
        chk("tie2_i_rdata", i_mem_rdata, pat_i);
        chk("tie2_d_resp", d_mem_resp, 0);
        cyc();
        mem_resp = 1'b0; i_mem_read = 1'b0; d_mem_read = 1'b0;
        chk("tie2_i_cnt", i_grant_cnt, 1);
        chk("tie2_d_cnt", d_grant_cnt, 1);
        cyc();

        // Writeback with read also high counts as a write
        d_mem_write = 1'b1; d_mem_read = 1'b1;
        d_mem_addr = 32'h0000_1000; d_mem_wdata = pat_1234;
        cyc();
        d_mem_wdata = '0;
        #1;
        chk("wb_mem_write", mem_write, 1);
        chk("wb_mem_read", mem_read, 0);
        chk("wb_mem_addr", mem_addr, 32'h0000_1000);
        chk("wb_mem_wdata", mem_wdata, pat_1234);
        cyc();
        chk("wb2_mem_read", mem_read, 0);
        mem_resp = 1'b1; mem_rdata = '0;
        #1;
        chk("wb_d_resp", d_mem_resp, 1);
        chk("wb_i_resp", i_mem_resp, 0);
        cyc();
        mem_resp = 1'b0; d_mem_write = 1'b0; d_mem_read = 1'b0;
        #1;
        chk("wb_done_write", mem_write, 0);
        chk("wb_d_cnt", d_grant_cnt, 2);
        cyc();

        // Reset in the middle of a writeback burst
        d_mem_write = 1'b1; d_mem_addr = 32'h0000_2000; d_mem_wdata = pat_a5;
        cyc();
        chk("mid_mem_write", mem_write, 1);
        cyc();
        reset = 1'b1;
        #1;
        chk("mid_rst_write", mem_write, 0);
        chk("mid_rst_i_cnt", i_grant_cnt, 0);
        chk("mid_rst_d_cnt", d_grant_cnt, 0);
        chk("mid_rst_wdata", mem_wdata, 0);
        d_mem_write = 1'b0;
        cyc();
        reset = 1'b0;
        i_mem_read = 1'b1; i_mem_addr = 32'h0000_0300;
        d_mem_read = 1'b1; d_mem_addr = 32'h0000_0400;
        cyc();
        chk("post_rst_addr", mem_addr, 32'h0000_0400);
        chk("post_rst_read", mem_read, 1);
        chk("post_rst_write", mem_write, 0);
        mem_resp = 1'b1; mem_rdata = pat_d;
        #1;
        chk("post_rst_d_resp", d_mem_resp, 1);
        cyc();
        mem_resp = 1'b0; i_mem_read = 1'b0; d_mem_read = 1'b0;
        chk("post_rst_d_cnt", d_grant_cnt, 1);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
